token_decoder: RTL and testbench

Converts a stream of token IDs back into a zero-terminated character string: the reverse of the tokenising encoder. For each token the block walks the vocabulary SRAM, skips `token-1` zero-terminated words, and copies the selected word byte-by-byte into the output SRAM. It sits beside the encoder, drives its own synchronous-read SRAM ports for the token, vocab and output memories, and is controlled by a start/busy/done handshake.

---
 rtl/token_decoder.sv | 174 +++++++++++++++++
 tb/tb_token_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/token_decoder.sv
// token_decoder
//   Turns a zero-terminated stream of token IDs back into a zero-terminated
//   character string. Token k (k >= 1) selects the k-th zero-terminated word
//   of the vocab SRAM. The word is copied byte-by-byte into the output SRAM.
//   All three SRAMs have a synchronous read with 1-cycle latency.
//
//   Optional build macro: TOKEN_DECODER_SEP_EN
//     defined   : SEP_CHAR is written before every word except the first
//     undefined : words are concatenated directly (no SEP state)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, accepted only when idle
//   busy                high from the cycle after start until done
//   done                one-cycle pulse, coincides with the terminator write
//   err                 sticky until next accepted start (unknown token / overflow)
//   out_len             characters written, excluding the terminator
//   tok_addr/tok_data   token SRAM read port
//   voc_addr/voc_data   vocab SRAM read port
//   out_addr/out_wdata/out_we   output SRAM write port
module token_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEP_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] out_len,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  out_we
);

    typedef enum logic [2:0] {
        IDLE, T_RD, T_CHK, SEP, V_RD, V_CHK, TERM, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [DATA_WIDTH-1:0] ONE_D = 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ta;     // token address
    logic [ADDR_WIDTH-1:0] va;     // vocab address
    logic [ADDR_WIDTH-1:0] oa;     // output address
    logic [DATA_WIDTH-1:0] skip;   // words still to skip
    logic                  first;  // no word written yet

    // The read addresses are the address registers themselves, so the SRAM
    // samples them at the end of T_RD / V_RD and data arrives in the CHK state.
    assign tok_addr = ta;
    assign voc_addr = va;

`ifndef TOKEN_DECODER_SEP_EN
    logic unused_sep;
    assign unused_sep = ^SEP_CHAR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ta        <= '0;
            va        <= '0;
            oa        <= '0;
            skip      <= '0;
            first     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_len   <= '0;
            out_addr  <= '0;
            out_wdata <= '0;
            out_we    <= 1'b0;
        end else begin
            out_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ta    <= '0;
                        oa    <= '0;
                        err   <= 1'b0;
                        first <= 1'b1;
                        busy  <= 1'b1;
                        state <= T_RD;
                    end
                end
                T_RD: state <= T_CHK;
                T_CHK: begin
                    if (tok_data == '0) begin
                        state <= TERM;
                    end else begin
                        skip <= tok_data - ONE_D;
                        va   <= '0;
`ifdef TOKEN_DECODER_SEP_EN
                        state <= first ? V_RD : SEP;
`else
                        state <= V_RD;
`endif
                    end
                end
`ifdef TOKEN_DECODER_SEP_EN
                SEP: begin
                    // D-1 is reserved for the terminator
                    if (oa == LAST) begin
                        err   <= 1'b1;
                        state <= TERM;
                    end else begin
                        out_we    <= 1'b1;
                        out_addr  <= oa;
                        out_wdata <= SEP_CHAR;
                        oa        <= oa + ONE_A;
                        state     <= V_RD;
                    end
                end
`endif
                V_RD: state <= V_CHK;
                V_CHK: begin
                    if (skip != '0) begin
                        if (voc_data == '0)
                            skip <= skip - ONE_D;
                        // still skipping at the last vocab byte: word never found
                        if (va == LAST) begin
                            err   <= 1'b1;
                            state <= TERM;
                        end else begin
                            va    <= va + ONE_A;
                            state <= V_RD;
                        end
                    end else if (voc_data == '0) begin
                        // end of selected word; the last token slot implies end of stream
                        first <= 1'b0;
                        if (ta == LAST) begin
                            state <= TERM;
                        end else begin
                            ta    <= ta + ONE_A;
                            state <= T_RD;
                        end
                    end else if (va == LAST || oa == LAST) begin
                        err   <= 1'b1;
                        state <= TERM;
                    end else begin
                        out_we    <= 1'b1;
                        out_addr  <= oa;
                        out_wdata <= voc_data;
                        oa        <= oa + ONE_A;
                        va        <= va + ONE_A;
                        state     <= V_RD;
                    end
                end
                TERM: begin
                    out_we    <= 1'b1;
                    out_addr  <= oa;
                    out_wdata <= '0;
                    out_len   <= oa;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_token_decoder.sv
module tb_token_decoder;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam logic [7:0] SEPC = 8'h20;
`ifdef TOKEN_DECODER_SEP_EN
    localparam bit SEP_EN = 1'b1;
`else
    localparam bit SEP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err, out_we;
    logic [AW-1:0] out_len, tok_addr, voc_addr, out_addr;
    logic [DW-1:0] tok_data, voc_data, out_wdata;

    token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEP_CHAR(SEPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .out_len(out_len), .tok_addr(tok_addr), .tok_data(tok_data),
        .voc_addr(voc_addr), .voc_data(voc_data), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_we(out_we)
    );

    always #5 clk = ~clk;

    logic [7:0] tok_mem [D];
    logic [7:0] voc_mem [D];

    always @(posedge clk) begin
        tok_data <= tok_mem[tok_addr];
        voc_data <= voc_mem[voc_addr];
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_wr(input int a, input int d);
        wr_t w;
        w.a = a[AW-1:0];
        w.d = d[DW-1:0];
        exp_q.push_back(w);
    endfunction

    // Output-side monitor: every write must match the next expected write.
    always @(negedge clk) begin
        if (out_we) begin
            if (exp_q.size() == 0) begin
                check("wr_extra", {28'd0, out_addr}, 32'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {28'd0, out_addr}, {28'd0, e.a});
                check("wr_data", {24'd0, out_wdata}, {24'd0, e.d});
            end
        end
        if (done) done_cnt++;
    end

    // String-level reference: expected write sequence, length and error flag.
    task automatic model(output int len, output bit e);
        int  oa;
        int  skip;
        int  va;
        int  tok;
        bit  first;
        bit  stop;
        logic [7:0] b;
        oa = 0; first = 1'b1; stop = 1'b0; e = 1'b0;
        for (int ta = 0; ta < D && !stop; ta++) begin
            tok = int'(tok_mem[ta]);
            if (tok == 0) break;
            if (SEP_EN && !first) begin
                if (oa == D-1) begin e = 1'b1; break; end
                push_wr(oa, SEPC); oa++;
            end
            skip = tok - 1;
            va = 0;
            forever begin
                b = voc_mem[va];
                if (skip != 0) begin
                    if (b == 0) skip--;
                    if (va == D-1) begin e = 1'b1; stop = 1'b1; break; end
                    va++;
                end else if (b == 0) begin
                    first = 1'b0;
                    break;
                end else if (va == D-1 || oa == D-1) begin
                    e = 1'b1; stop = 1'b1; break;
                end else begin
                    push_wr(oa, b); oa++; va++;
                end
            end
        end
        push_wr(oa, 0);
        len = oa;
    endtask

    task automatic clr_toks();
        for (int i = 0; i < D; i++) tok_mem[i] = 8'h00;
    endtask

    // One full decode; poke re-pulses start while busy.
    task automatic run(input string tag, input bit poke, output int cyc, output int len_obs);
        int  len;
        bit  e;
        bit  seen;
        model(len, e);
        done_cnt = 0;
        seen = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        len_obs = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            start = (poke && i == 5);
            if (done) begin
                cyc = i;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            len_obs = int'(out_len);
            check({tag, "_len"}, {28'd0, out_len}, len);
            check({tag, "_err"}, {31'd0, err}, {31'd0, e});
            check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        int lo;
        for (int i = 0; i < D; i++) voc_mem[i] = 8'h00;
        voc_mem[0] = 8'h68; voc_mem[1] = 8'h69;   // "hi"
        voc_mem[3] = 8'h79; voc_mem[4] = 8'h6f;   // "yo"
        voc_mem[6] = 8'h6f; voc_mem[7] = 8'h6b;   // "ok"
        clr_toks();

        #1;
        check("rst_outs", {busy, done, err, out_we, out_len, tok_addr, voc_addr, out_addr, out_wdata},
              32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic: tokens 2,1,0
        clr_toks(); tok_mem[0] = 8'd2; tok_mem[1] = 8'd1;
        run("basic", 1'b0, cyc, lo);
        check("basic_len_lit", lo, SEP_EN ? 32'd5 : 32'd4);

        // empty stream, latency bound
        clr_toks();
        run("empty", 1'b0, cyc, lo);
        check("empty_lat", {31'd0, (cyc <= 4)}, 32'd1);

        // unknown token
        clr_toks(); tok_mem[0] = 8'hFF;
        run("unk", 1'b0, cyc, lo);
        check("unk_err_lit", {31'd0, err}, 32'd1);

        // last word that ends exactly at D-1 is legal; the next one is unknown
        clr_toks(); tok_mem[0] = 8'd10;
        run("w10", 1'b0, cyc, lo);
        clr_toks(); tok_mem[0] = 8'd11;
        run("w11", 1'b0, cyc, lo);

        // overflow: six "hi" then end; ten "hi" then end
        clr_toks(); for (int i = 0; i < 6; i++) tok_mem[i] = 8'd1;
        run("ovf6", 1'b0, cyc, lo);
        clr_toks(); for (int i = 0; i < 10; i++) tok_mem[i] = 8'd1;
        run("ovf10", 1'b0, cyc, lo);
        check("ovf10_err_lit", {31'd0, err}, 32'd1);
        check("ovf10_len_lit", lo, 32'd15);

        // empty word in the middle
        clr_toks(); tok_mem[0] = 8'd1; tok_mem[1] = 8'd4; tok_mem[2] = 8'd2;
        run("emptyw", 1'b0, cyc, lo);

        // token wrap: every slot holds an empty word, no terminator token
        for (int i = 0; i < D; i++) tok_mem[i] = 8'd4;
        run("wrap", 1'b0, cyc, lo);

        // start while busy is ignored
        clr_toks(); tok_mem[0] = 8'd3; tok_mem[1] = 8'd2;
        run("poke", 1'b1, cyc, lo);

        // reset mid-decode, in the first V_CHK of token 3
        clr_toks(); tok_mem[0] = 8'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;       // T_RD
        @(negedge clk);                    // T_CHK
        @(negedge clk);                    // V_RD
        @(negedge clk);                    // V_CHK
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {busy, done, err, out_we, out_len, tok_addr, voc_addr, out_addr, out_wdata},
              32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        run("restart", 1'b0, cyc, lo);
        check("restart_len_lit", lo, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
